seq_decoder: RTL and testbench
==============================

# seq_decoder

Parametrised, registered N-to-2^N one-hot decoder with a second, self-timed scan mode. This is the next-generation replacement for the fixed combinational 2-to-4 decoder. In decode mode it latches a select value and drives the matching one-hot output. In scan mode it walks the active output across all 2^N lines with a programmable dwell, for digit/row multiplexing. The block sits between control logic and the per-line enables of display, bank-select or row-strobe fabric.

## Interface
Parameters:
- N, 2, select width; output width is 2^N (N ≥ 1).
- DWELL, 4, cycles each output stays active in scan mode (DWELL ≥ 1).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  block enable; 0 forces outputs inactive.
- mode  input  1  0 = decode, 1 = scan.
- load  input  1  decode-mode strobe: capture i this cycle.
- i  input  N  select value for decode mode.
- y  output  2^N  registered one-hot output; all-zero when inactive.
- idx  output  N  binary index of the active y bit.
- valid  output  1  1 when y holds exactly one active bit.
- wrap  output  1  one-cycle pulse when scan advances from index 2^N-1 to 0.

## Operation
- Reset value of every output: y=0, idx=0, valid=0, wrap=0. Internal state: IDLE, dwell counter 0.
- The reset value is visible on the edge after rst is sampled high.
- rst dominates every other input, including mid-scan and mid-load.
- States and transitions, evaluated every rising edge with rst=0:
  - IDLE: y=0, valid=0.
    - en=1, mode=0, load=1 → DECODE.
    - en=1, mode=1 → SCAN.
    - Otherwise stay in IDLE.
  - DECODE, on load=1: y = 1<<i, idx=i, valid=1.
    - With load=0, y, idx and valid hold their values.
    - en=0 → IDLE.
    - mode=1 → SCAN.
  - SCAN: on entry, idx=0, y=1<<0, dwell counter=0, valid=1.
    - Each cycle the dwell counter increments.
    - When the counter reaches DWELL-1, it clears and idx increments modulo 2^N; y follows idx.
    - wrap=1 for exactly the cycle in which idx becomes 0 through a wrap. It is not asserted on SCAN entry.
    - en=0 → IDLE.
    - mode=0 with load=1 → DECODE, capturing i.
    - mode=0 with load=0 → DECODE, holding the last scan y and idx.
- In SCAN, load and i are ignored.
- Leaving and re-entering SCAN always restarts at idx=0 with a fresh dwell.
- Any en=0 cycle returns the block to IDLE. From there:
  - y=0, valid=0, wrap=0.
  - idx holds its last value.
  - The dwell counter clears.
- At all times y equals one-hot(idx) when valid=1, and y=0 when valid=0. No other patterns are legal.
- Width rules:
  - The dwell counter is clog2(DWELL) bits wide, minimum 1 bit.
  - idx wraps naturally at N bits.
  - DWELL=1 advances idx every cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Decode latency: i and load sampled at edge k → y, idx and valid valid after edge k.
  - Back-to-back loads are accepted every cycle.
- Scan entry: en=1, mode=1 sampled at edge k → y=1<<0 after edge k.
  - y advances to 1<<1 after edge k+DWELL.
  - The full scan period is DWELL·2^N cycles.
- wrap is high after edge k+DWELL·2^N, for one cycle only, with y=1<<0 in that same cycle.
- Disable: en=0 sampled at edge k → y=0, valid=0 after edge k.
- Simultaneous events, in priority order: rst > en=0 > mode change > load > dwell advance.
- A mode change and a dwell expiry in the same cycle: the mode change wins, and no wrap pulse is issued.

## Test plan
All scenarios use N=2, DWELL=3 unless noted.

- Reset: drive rst=1 for 2 cycles with en=1, mode=1 → y=4'b0000, idx=0, valid=0, wrap=0 throughout.
- Decode sweep: en=1, mode=0, with load pulses i=0,1,2,3 on consecutive cycles → y=0001,0010,0100,1000, each one cycle after its load. Then load=0 for 5 cycles → y holds 1000.
- Scan: en=1, mode=1 for 14 cycles from IDLE.
  - y sequence: 0001×3, 0010×3, 0100×3, 1000×3, 0001…
  - wrap=1 only in the cycle where y first returns to 0001 (cycle 13 after entry).
- DWELL=1 variant: scan → y changes every cycle; wrap pulses every 4 cycles.
- Mid-operation disturbances:
  - In scan at y=0100, drive en=0 for 1 cycle, then en=1 → y=0000 for one cycle, then a restart at 0001 with a full 3-cycle dwell.
  - In scan, assert rst → all outputs are zero on the next edge.
- Mode switch: in scan at y=0010, set mode=0 with load=1, i=3 → next y=1000, valid=1, no wrap pulse.

Source files
------------

// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with a self-timed scan mode that walks
// the active line across all outputs with a programmable dwell per line.
module seq_decoder #(
  parameter int unsigned N     = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        i,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                valid,
  output logic                wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [N-1:0]    r_idx;
  logic [N-1:0]    w_idx_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_wrap;
  logic            w_wrap_nxt;
  logic [W-1:0]    r_y;
  logic [W-1:0]    w_y_nxt;

  // Next-state and next-output logic; priority en=0 > mode change > load > dwell
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DECODE: begin
          if (mode) begin
            w_state_nxt = S_SCAN;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b1;
          end else if (load) begin
            w_state_nxt = S_DECODE;
            w_idx_nxt   = i;
            w_valid_nxt = 1'b1;
          end
        end
        S_SCAN: begin
          if (!mode) begin
            // Leaving scan keeps the current line unless a new select is loaded
            w_state_nxt = S_DECODE;
            w_cnt_nxt   = '0;
            if (load) begin
              w_idx_nxt = i;
            end
          end else if (r_cnt == CW'(DWELL - 1)) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = r_idx + N'(1);
            w_wrap_nxt = (r_idx == N'(W - 1));
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      endcase
    end

    w_y_nxt = w_valid_nxt ? (W'(1) << w_idx_nxt) : '0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign y     = r_y;
  assign idx   = r_idx;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: a DWELL=3 and a DWELL=1 instance share stimulus.
module tb_seq_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       load;
  logic [1:0] i;

  logic [3:0] y0;
  logic [1:0] idx0;
  logic       valid0;
  logic       wrap0;
  logic [3:0] y1;
  logic [1:0] idx1;
  logic       valid1;
  logic       wrap1;

  int n_vec;
  int n_err;

  seq_decoder #(.N(2), .DWELL(3)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .load  (load),
    .i     (i),
    .y     (y0),
    .idx   (idx0),
    .valid (valid0),
    .wrap  (wrap0)
  );

  seq_decoder #(.N(2), .DWELL(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .load  (load),
    .i     (i),
    .y     (y1),
    .idx   (idx1),
    .valid (valid1),
    .wrap  (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [3:0] ey, input logic [1:0] eidx,
                      input logic ev, input logic ew);
    chk({tag, ".y"},     32'(y0),     32'(ey));
    chk({tag, ".idx"},   32'(idx0),   32'(eidx));
    chk({tag, ".valid"}, 32'(valid0), 32'(ev));
    chk({tag, ".wrap"},  32'(wrap0),  32'(ew));
  endtask

  task automatic chk1(input string tag, input logic [3:0] ey, input logic [1:0] eidx,
                      input logic ev, input logic ew);
    chk({tag, ".y1"},     32'(y1),     32'(ey));
    chk({tag, ".idx1"},   32'(idx1),   32'(eidx));
    chk({tag, ".valid1"}, 32'(valid1), 32'(ev));
    chk({tag, ".wrap1"},  32'(wrap1),  32'(ew));
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0; i = 2'd0;

    // Reset held for two cycles while scan is requested
    tick(); chk0("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0); chk1("rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick(); chk0("rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Decode sweep, back-to-back loads
    mode = 1'b0; load = 1'b1;
    i = 2'd0; tick(); chk0("dec_i0", 4'b0001, 2'd0, 1'b1, 1'b0);
    i = 2'd1; tick(); chk0("dec_i1", 4'b0010, 2'd1, 1'b1, 1'b0);
    i = 2'd2; tick(); chk0("dec_i2", 4'b0100, 2'd2, 1'b1, 1'b0);
    i = 2'd3; tick(); chk0("dec_i3", 4'b1000, 2'd3, 1'b1, 1'b0);
    load = 1'b0; i = 2'd1;
    for (int t = 0; t < 5; t++) begin
      tick(); chk0("dec_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    end

    // Disable: outputs drop, idx holds
    en = 1'b0; tick(); chk0("dis", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Scan from IDLE for 14 cycles: 3 cycles per line, wrap on cycle 13
    en = 1'b1; mode = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      k = ((t - 1) / 3) % 4;
      tick(); chk0("scan", 4'b0001 << k, 2'(k), 1'b1, (t == 13));
    end
    tick(); chk0("scan15", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk0("scan16", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Mode switch with load while at 0010
    mode = 1'b0; load = 1'b1; i = 2'd3;
    tick(); chk0("sw_load", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Re-enter scan restarts at line 0; run to 0100
    mode = 1'b1; load = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      k = (t - 1) / 3;
      tick(); chk0("rescan", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
    end

    // One-cycle disable at 0100, then restart with full dwell
    en = 1'b0; tick(); chk0("blip_off", 4'b0000, 2'd2, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk0("blip_on1", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk0("blip_on2", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk0("blip_on3", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick(); chk0("blip_on4", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset mid-scan
    rst = 1'b1; tick(); chk0("rst_scan", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0; tick(); chk0("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Back to IDLE, then scan both instances side by side
    en = 1'b0; tick(); chk1("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      k = (t - 1) % 4;
      chk1("scan_d1", 4'b0001 << k, 2'(k), 1'b1, (t > 1) && (k == 0));
      k = ((t - 1) / 3) % 4;
      chk0("scan_d3", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
    end

    // Mode change coinciding with dwell expiry at the last line: no wrap
    mode = 1'b0; load = 1'b0;
    tick();
    chk0("sw_expiry", 4'b1000, 2'd3, 1'b1, 1'b0);
    chk1("sw_expiry", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    chk0("sw_hold", 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
